counter_alarm_sched: RTL and testbench

Alarm scheduler for the free-running 64-bit simulation counter driven by the SiCo-controlled `clk`/`rst`. The block owns the counter and its enable/clear control. It shares the counter between `N_REQ` requesters, each of which arms one absolute-deadline alarm through a valid/ready handshake. A round-robin arbiter admits at most one arm per cycle, and each requester gets a one-cycle `fire` pulse when the counter reaches its deadline.

---
 rtl/counter_alarm_pkg.sv | 24 ++
 rtl/counter_alarm_sched_arb.sv | 46 ++++
 rtl/counter_alarm_sched.sv | 108 ++++++++++
 tb/tb_counter_alarm_sched.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_alarm_pkg.sv
// Shared types and helpers for the counter alarm scheduler.
package counter_alarm_pkg;

  localparam int unsigned CNT_W_DEF = 64;
  localparam int unsigned CNT_W_MAX = 64;
  localparam int unsigned IDX_W     = $clog2(CNT_W_MAX);

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } slot_state_e;

  // A deadline is late when it is already due: the modular distance from the
  // counter is zero or lies in the "past" half of the counter range.
  function automatic logic is_late(input logic [CNT_W_MAX-1:0] deadline,
                                   input logic [CNT_W_MAX-1:0] cnt,
                                   input int unsigned          w);
    logic [CNT_W_MAX-1:0] delta;
    delta = deadline - cnt;
    if (w < CNT_W_MAX) delta = delta & ((CNT_W_MAX'(1) << w) - CNT_W_MAX'(1));
    return (delta == '0) || delta[IDX_W'(w - 1)];
  endfunction

endpackage

// File: rtl/counter_alarm_sched_arb.sv
// Round-robin arbiter: grants the first eligible index at or after rr_ptr.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] eligible_i,
  input  logic         accept_valid_i,
  output logic [N-1:0] grant_o
);

  localparam int unsigned PW = $clog2(N);

  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic [PW-1:0] gidx;
  logic          found;

  function automatic logic [PW-1:0] wrap_idx(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    if (s >= N) s = s - N;
    return PW'(s);
  endfunction

  always_comb begin
    grant_o  = '0;
    found    = 1'b0;
    gidx     = '0;
    rr_ptr_d = rr_ptr_q;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found && accept_valid_i && eligible_i[wrap_idx(rr_ptr_q, k)]) begin
        grant_o[wrap_idx(rr_ptr_q, k)] = 1'b1;
        gidx  = wrap_idx(rr_ptr_q, k);
        found = 1'b1;
      end
    end
    // Valid is part of eligibility, so any grant is an accept.
    if (found) rr_ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) rr_ptr_q <= '0;
    else     rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/counter_alarm_sched.sv
// Free-running counter plus N_REQ absolute-deadline alarm slots sharing it.
// Handshake: an arm is accepted when req_valid_i[i] and req_ready_o[i] are both high at the edge; ready never depends on... only valid and slot state.
module counter_alarm_sched
  import counter_alarm_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cnt_en_i,
  input  logic             cnt_clr_i,
  output logic [CNT_W-1:0] cnt_o,
  input  logic [N_REQ-1:0] req_valid_i,
  input  logic [CNT_W-1:0] req_deadline_i [N_REQ],
  output logic [N_REQ-1:0] req_ready_o,
  input  logic [N_REQ-1:0] req_cancel_i,
  output logic [N_REQ-1:0] armed_o,
  output logic [N_REQ-1:0] fire_o,
  output logic [N_REQ-1:0] late_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] dl_q [N_REQ];
  logic [CNT_W-1:0] dl_d [N_REQ];
  slot_state_e      state_q [N_REQ];
  slot_state_e      state_d [N_REQ];
  logic [N_REQ-1:0] fire_q, fire_d, late_q, late_d;
  logic [N_REQ-1:0] eligible, grant, match, acc_late;

  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr_i)     cnt_d = '0;
    else if (cnt_en_i) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    eligible = '0;
    armed_o  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      eligible[i] = req_valid_i[i] && (state_q[i] == IDLE);
      armed_o[i]  = (state_q[i] == ARMED);
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk            (clk),
    .rst            (rst),
    .eligible_i     (eligible),
    .accept_valid_i (!rst),
    .grant_o        (grant)
  );

  assign req_ready_o = grant;

  always_comb begin
    match    = '0;
    acc_late = '0;
    fire_d   = '0;
    late_d   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      state_d[i]  = state_q[i];
      dl_d[i]     = dl_q[i];
      match[i]    = (state_q[i] == ARMED) && (cnt_q == dl_q[i]);
      acc_late[i] = grant[i] && is_late(CNT_W_MAX'(req_deadline_i[i]), CNT_W_MAX'(cnt_q), CNT_W);
      case (state_q[i])
        IDLE: begin
          if (grant[i]) begin
            dl_d[i] = req_deadline_i[i];
            if (!acc_late[i]) state_d[i] = ARMED;
          end
        end
        ARMED: begin
          // A match in the same cycle as a cancel still fires.
          if (match[i] || req_cancel_i[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
      fire_d[i] = match[i] | acc_late[i];
      late_d[i] = acc_late[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      fire_q <= '0;
      late_q <= '0;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= IDLE;
        dl_q[i]    <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      fire_q <= fire_d;
      late_q <= late_d;
      for (int i = 0; i < N_REQ; i++) begin
        state_q[i] <= state_d[i];
        dl_q[i]    <= dl_d[i];
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign fire_o = fire_q;
  assign late_o = late_q;

endmodule

// File: tb/tb_counter_alarm_sched.sv
// Directed bench for counter_alarm_sched: a 64-bit instance plus an 8-bit one for wrap-around.
module tb_counter_alarm_sched;

  logic        clk = 1'b0;
  logic        rst;
  always #5 clk = ~clk;

  logic        en, clr;
  logic [63:0] cnt;
  logic [3:0]  valid, ready, cancel, armed, fire, late;
  logic [63:0] dl [4];

  logic        en8, clr8;
  logic [7:0]  cnt8;
  logic [3:0]  valid8, ready8, cancel8, armed8, fire8, late8;
  logic [7:0]  dl8 [4];

  int total = 0;
  int bad   = 0;

  counter_alarm_sched #(.N_REQ(4), .CNT_W(64)) dut (
    .clk(clk), .rst(rst), .cnt_en_i(en), .cnt_clr_i(clr), .cnt_o(cnt),
    .req_valid_i(valid), .req_deadline_i(dl), .req_ready_o(ready),
    .req_cancel_i(cancel), .armed_o(armed), .fire_o(fire), .late_o(late)
  );

  counter_alarm_sched #(.N_REQ(4), .CNT_W(8)) dut8 (
    .clk(clk), .rst(rst), .cnt_en_i(en8), .cnt_clr_i(clr8), .cnt_o(cnt8),
    .req_valid_i(valid8), .req_deadline_i(dl8), .req_ready_o(ready8),
    .req_cancel_i(cancel8), .armed_o(armed8), .fire_o(fire8), .late_o(late8)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; valid = '0; cancel = '0;
    en8 = 1'b0; clr8 = 1'b0; valid8 = '0; cancel8 = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic set_cnt(input int v);
    clr = 1'b1; en = 1'b0;
    step();
    clr = 1'b0; en = 1'b1;
    repeat (v) step();
    en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 4'hF; valid8 = 4'hF;
    step(); step(); settle();
    total++; if (cnt !== 64'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", cnt); end
    total++; if (armed !== 4'b0) begin bad++; $display("FAIL reset_armed got=%b exp=0000", armed); end
    total++; if (fire !== 4'b0 || late !== 4'b0) begin bad++; $display("FAIL reset_pulses fire=%b late=%b exp=0000", fire, late); end
    total++; if (ready !== 4'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0000", ready); end
    total++; if (ready8 !== 4'b0) begin bad++; $display("FAIL reset_ready8 got=%b exp=0000", ready8); end
    rst = 1'b0;
    settle();
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL reset_ptr got=%b exp=0001", ready); end
    valid = '0; valid8 = '0;
    step();
  endtask

  task automatic test_counter();
    do_reset();
    total++; if (cnt !== 64'd0) begin bad++; $display("FAIL cnt_start got=%0d exp=0", cnt); end
    en = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      total++; if (cnt !== 64'(i)) begin bad++; $display("FAIL cnt_inc got=%0d exp=%0d", cnt, i); end
    end
    clr = 1'b1;
    step();
    total++; if (cnt !== 64'd0) begin bad++; $display("FAIL cnt_clr_prio got=%0d exp=0", cnt); end
    clr = 1'b0; en = 1'b0;
  endtask

  task automatic test_basic();
    int fires, lates;
    logic [63:0] fire_at;
    do_reset();
    set_cnt(10);
    dl[0] = 64'd20; valid = 4'b0001; en = 1'b1;
    settle();
    total++; if (ready !== 4'b0001) begin bad++; $display("FAIL basic_ready got=%b exp=0001", ready); end
    step();
    valid = '0;
    total++; if (armed !== 4'b0001) begin bad++; $display("FAIL basic_armed got=%b exp=0001", armed); end
    fires = 0; lates = 0; fire_at = '0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (fire[0]) begin fires++; fire_at = cnt; end
      if (late[0]) lates++;
    end
    en = 1'b0;
    total++; if (fires != 1) begin bad++; $display("FAIL basic_fire_count got=%0d exp=1", fires); end
    total++; if (fire_at !== 64'd21) begin bad++; $display("FAIL basic_fire_time cnt_at_fire=%0d exp=21", fire_at); end
    total++; if (lates != 0) begin bad++; $display("FAIL basic_late got=%0d exp=0", lates); end
    total++; if (armed !== 4'b0) begin bad++; $display("FAIL basic_disarm got=%b exp=0000", armed); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp;
    do_reset();
    for (int i = 0; i < 4; i++) dl[i] = 64'(1000 + i);
    valid = 4'hF;
    settle();
    exp = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      total++; if (ready !== exp) begin bad++; $display("FAIL rr_grant%0d got=%b exp=%b", k, ready, exp); end
      step();
      exp = exp << 1;
    end
    total++; if (armed !== 4'hF || ready !== 4'b0) begin bad++; $display("FAIL rr_full armed=%b ready=%b exp=1111/0000", armed, ready); end
    cancel = 4'b0010;
    step();
    cancel = '0;
    settle();
    total++; if (armed !== 4'b1101) begin bad++; $display("FAIL rr_cancel_armed got=%b exp=1101", armed); end
    total++; if (ready !== 4'b0010) begin bad++; $display("FAIL rr_regrant got=%b exp=0010", ready); end
    step();
    total++; if (armed !== 4'hF) begin bad++; $display("FAIL rr_rearm got=%b exp=1111", armed); end
    valid = '0; cancel = 4'hF;
    step();
    cancel = '0;
    total++; if (armed !== 4'b0 || fire !== 4'b0) begin bad++; $display("FAIL rr_cancel_all armed=%b fire=%b exp=0000/0000", armed, fire); end
  endtask

  task automatic test_late();
    do_reset();
    set_cnt(100);
    dl[2] = 64'd100; valid = 4'b0100;
    settle();
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL late_ready got=%b exp=0100", ready); end
    step();
    dl[2] = 64'd50;
    total++; if (fire !== 4'b0100 || late !== 4'b0100 || armed !== 4'b0) begin bad++; $display("FAIL late_equal fire=%b late=%b armed=%b exp=0100/0100/0000", fire, late, armed); end
    settle();
    total++; if (ready !== 4'b0100) begin bad++; $display("FAIL late_still_ready got=%b exp=0100", ready); end
    step();
    valid = '0;
    total++; if (fire !== 4'b0100 || late !== 4'b0100 || armed !== 4'b0) begin bad++; $display("FAIL late_past fire=%b late=%b armed=%b exp=0100/0100/0000", fire, late, armed); end
    step();
    total++; if (fire !== 4'b0 || late !== 4'b0) begin bad++; $display("FAIL late_one_cycle fire=%b late=%b exp=0000", fire, late); end
  endtask

  task automatic test_cancel();
    int fires;
    dl[1] = 64'd200; valid = 4'b0010;
    step();
    valid = '0;
    total++; if (armed !== 4'b0010) begin bad++; $display("FAIL cancel_arm got=%b exp=0010", armed); end
    cancel = 4'b0010;
    step();
    cancel = '0;
    total++; if (armed !== 4'b0 || fire !== 4'b0) begin bad++; $display("FAIL cancel_drop armed=%b fire=%b exp=0000/0000", armed, fire); end
    en = 1'b1; fires = 0;
    repeat (110) begin
      step();
      if (fire[1]) fires++;
    end
    en = 1'b0;
    total++; if (fires != 0) begin bad++; $display("FAIL cancel_no_fire got=%0d exp=0", fires); end

    set_cnt(50);
    dl[3] = 64'd60; valid = 4'b1000;
    step();
    valid = '0;
    total++; if (armed !== 4'b1000) begin bad++; $display("FAIL cm_arm got=%b exp=1000", armed); end
    en = 1'b1;
    for (int k = 0; k < 20 && cnt != 64'd60; k++) step();
    en = 1'b0;
    total++; if (cnt !== 64'd60) begin bad++; $display("FAIL cm_reach cnt=%0d exp=60", cnt); end
    cancel = 4'b1000;
    step();
    cancel = '0;
    total++; if (fire !== 4'b1000 || armed !== 4'b0) begin bad++; $display("FAIL cm_match_wins fire=%b armed=%b exp=1000/0000", fire, armed); end
    step();
    total++; if (fire !== 4'b0) begin bad++; $display("FAIL cm_single fire=%b exp=0000", fire); end

    dl[2] = 64'd70; valid = 4'b0100;
    step();
    valid = '0; cancel = 4'b0001;
    step();
    cancel = '0;
    total++; if (armed !== 4'b0100 || fire !== 4'b0) begin bad++; $display("FAIL cancel_idle armed=%b fire=%b exp=0100/0000", armed, fire); end
    cancel = 4'b0100;
    step();
    cancel = '0;
  endtask

  task automatic test_hold_clear();
    int fires;
    logic [63:0] fire_at;
    do_reset();
    set_cnt(3);
    dl[0] = 64'd5; valid = 4'b0001;
    step();
    valid = '0; fires = 0;
    repeat (30) begin
      step();
      if (fire[0]) fires++;
    end
    total++; if (armed !== 4'b0001 || fires != 0 || cnt !== 64'd3) begin bad++; $display("FAIL hold armed=%b fires=%0d cnt=%0d exp=0001/0/3", armed, fires, cnt); end
    clr = 1'b1;
    step();
    clr = 1'b0;
    total++; if (cnt !== 64'd0 || armed !== 4'b0001) begin bad++; $display("FAIL clr_retain cnt=%0d armed=%b exp=0/0001", cnt, armed); end
    en = 1'b1; fires = 0; fire_at = '0;
    repeat (10) begin
      step();
      if (fire[0]) begin fires++; fire_at = cnt; end
    end
    en = 1'b0;
    total++; if (fires != 1 || fire_at !== 64'd6) begin bad++; $display("FAIL clr_refire fires=%0d cnt_at_fire=%0d exp=1/6", fires, fire_at); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_cnt(10);
    dl[0] = 64'd11; dl[1] = 64'd500; dl[2] = 64'd600; valid = 4'b0111;
    step(); step(); step();
    valid = '0;
    total++; if (armed !== 4'b0111) begin bad++; $display("FAIL rstmid_arm got=%b exp=0111", armed); end
    en = 1'b1;
    step();
    total++; if (cnt !== 64'd11) begin bad++; $display("FAIL rstmid_cnt got=%0d exp=11", cnt); end
    rst = 1'b1; valid = 4'hF;
    settle();
    total++; if (ready !== 4'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0000", ready); end
    step();
    rst = 1'b0; valid = '0; en = 1'b0;
    total++; if (armed !== 4'b0 || fire !== 4'b0 || late !== 4'b0 || cnt !== 64'd0) begin bad++; $display("FAIL rstmid_clear armed=%b fire=%b late=%b cnt=%0d exp=0", armed, fire, late, cnt); end
    step();
    total++; if (fire !== 4'b0) begin bad++; $display("FAIL rstmid_nofire got=%b exp=0000", fire); end
  endtask

  task automatic test_wrap();
    int fires, lates;
    logic [7:0] fire_at;
    do_reset();
    clr8 = 1'b1;
    step();
    clr8 = 1'b0; en8 = 1'b1;
    repeat (253) step();
    en8 = 1'b0;
    total++; if (cnt8 !== 8'd253) begin bad++; $display("FAIL wrap_start got=%0d exp=253", cnt8); end
    dl8[0] = 8'd1; valid8 = 4'b0001;
    settle();
    total++; if (ready8 !== 4'b0001) begin bad++; $display("FAIL wrap_ready got=%b exp=0001", ready8); end
    step();
    valid8 = '0;
    total++; if (armed8 !== 4'b0001 || late8 !== 4'b0 || fire8 !== 4'b0) begin bad++; $display("FAIL wrap_arm armed=%b late=%b fire=%b exp=0001/0000/0000", armed8, late8, fire8); end
    en8 = 1'b1; fires = 0; lates = 0; fire_at = '0;
    repeat (6) begin
      step();
      if (fire8[0]) begin fires++; fire_at = cnt8; end
      if (late8[0]) lates++;
    end
    en8 = 1'b0;
    total++; if (cnt8 !== 8'd3) begin bad++; $display("FAIL wrap_cnt got=%0d exp=3", cnt8); end
    total++; if (fires != 1 || fire_at !== 8'd2 || lates != 0) begin bad++; $display("FAIL wrap_fire fires=%0d cnt_at_fire=%0d lates=%0d exp=1/2/0", fires, fire_at, lates); end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; valid = '0; cancel = '0;
    en8 = 1'b0; clr8 = 1'b0; valid8 = '0; cancel8 = '0;
    for (int i = 0; i < 4; i++) begin
      dl[i]  = '0;
      dl8[i] = '0;
    end
    test_reset();
    test_counter();
    test_basic();
    test_round_robin();
    test_late();
    test_cancel();
    test_hold_clear();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
